// File: rtl/mcc_serial_subtractor_if.sv
// Valid/ready operand and result bus for the serial Manchester-carry subtractor.
// The slave modport is the subtractor side and the master modport is the producer/consumer side.
interface mcc_serial_subtractor_if #(
    parameter int unsigned SIZE = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] diff;
    logic            bout;
    logic            ovf;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/mcc_serial_subtractor.sv
// Serial subtractor: diff = a - b - bin, one 4-bit Manchester-carry group per clock,
// with the inter-group carry held in a register between cycles.
module mcc_serial_subtractor #(
    parameter int unsigned SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mcc_serial_subtractor_if.slave bus
);
    localparam int unsigned NG = SIZE / 4;
    localparam int unsigned IW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NG - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_c;
    logic [SIZE-1:0] r_a;
    logic [SIZE-1:0] r_nb;
    logic [SIZE-1:0] r_diff;
    logic            r_bout;
    logic            r_ovf;
    logic            r_out_valid;

    logic            w_in_ready;
    logic            w_accept;
    logic [IW+1:0]   w_sh;
    logic [SIZE-1:0] w_a_sh;
    logic [SIZE-1:0] w_nb_sh;
    logic [3:0]      w_g;
    logic [3:0]      w_p;
    logic [3:0]      w_cv;
    logic [3:0]      w_gd;
    logic            w_cout;
    logic [SIZE-1:0] w_diff_nxt;

    assign w_in_ready = rst_n && ((r_state == StIdle) || ((r_state == StDone) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    // One group of the Manchester chain, seeded from the registered inter-group carry.
    always_comb begin
        logic c;
        w_sh    = {r_idx, 2'b00};
        w_a_sh  = r_a >> w_sh;
        w_nb_sh = r_nb >> w_sh;
        w_g     = w_a_sh[3:0] & w_nb_sh[3:0];
        w_p     = w_a_sh[3:0] ^ w_nb_sh[3:0];
        w_cv    = '0;
        c       = r_c;
        for (int i = 0; i < 4; i++) begin
            w_cv[i] = c;
            c       = w_g[i] | (w_p[i] & c);
        end
        w_cout     = c;
        w_gd       = w_p ^ w_cv;
        w_diff_nxt = (r_diff & ~(SIZE'(4'hF) << w_sh)) | (SIZE'(w_gd) << w_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_c         <= 1'b0;
            r_a         <= '0;
            r_nb        <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.a;
                r_nb  <= ~bus.b;
                r_c   <= ~bus.bin;
                r_idx <= '0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_accept) r_state <= StRun;
                end
                StRun: begin
                    r_diff <= w_diff_nxt;
                    r_c    <= w_cout;
                    if (r_idx == LastIdx) begin
                        r_bout      <= ~w_cout;
                        // Sign of b is recovered from the captured complement, not the live input.
                        r_ovf       <= (r_a[SIZE-1] != ~r_nb[SIZE-1]) &&
                                       (w_diff_nxt[SIZE-1] != r_a[SIZE-1]);
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= StDone;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? StRun : StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
endmodule
